// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment stopwatch:
// control states, write commands, and active-low glyph patterns {a,b,c,d,e,f,g}.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_START  = 2'b01;
  localparam logic [1:0] CMD_STOP   = 2'b10;
  localparam logic [1:0] CMD_RESUME = 2'b11;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // index = nibble value; bit 6 is segment a, bit 0 is segment g; 0 lights a segment
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // counter width able to hold values 0..n-1, never narrower than one bit
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to active-low seven-segment glyph, purely combinational.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/seg7_timer_param.sv
// Start/stop/resume BCD or hex event counter with a multiplexed seven-segment
// display scan; segment and anode pins are registered.
//
// state | meaning
// IDLE  | after reset, count frozen, STOP ignored
// RUN   | count advances once per prescale tick
// HOLD  | count and prescaler frozen until START or RESUME
module seg7_timer_param
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int PRESCALE = 1,
  parameter int REFRESH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_7seg,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ovf,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                e,
  output logic                f,
  output logic                g,
  output logic [N_DIGITS-1:0] AN
);

  localparam int CW = 4 * N_DIGITS;
  localparam int PW = bits_for(PRESCALE);
  localparam int RW = bits_for(REFRESH);
  localparam int IW = bits_for(N_DIGITS);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              wrap;
  logic              ovf_q;
  logic              hex_mode;
  logic [PW-1:0]     psc;
  logic [RW-1:0]     ref_cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        cur_nib;
  logic [6:0]        seg_dec;
  logic [6:0]        seg_q;
  logic [N_DIGITS-1:0] an_q;
  logic [1:0]        cmd;
  logic              cmd_valid;
  logic              tick;

  assign cmd       = wdata[1:0];
  assign cmd_valid = we_7seg && (cmd != CMD_NOP);
  assign tick      = (state == ST_RUN) && (psc == PW'(PRESCALE - 1));

  // Ripple-carry digit increment; hex and BCD differ only in the per-digit limit.
  always_comb begin
    logic carry;
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == (hex_mode ? 4'hF : 4'h9)) begin
          cnt_inc[4*i +: 4] = 4'h0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'h1;
          carry             = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      hex_mode <= 1'b0;
      psc      <= '0;
    end else begin
      if (we_7seg) begin
        hex_mode <= wdata[2];
      end
      if (cmd_valid) begin
        case (cmd)
          CMD_START: begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            psc   <= '0;
            state <= ST_RUN;
          end
          CMD_STOP: begin
            if (state != ST_IDLE) begin
              state <= ST_HOLD;
            end
          end
          CMD_RESUME: state <= ST_RUN;
          default:    state <= state;
        endcase
      end else if (tick) begin
        psc <= '0;
        cnt <= cnt_inc;
        if (wrap) begin
          ovf_q <= 1'b1;
        end
      end else if (state == ST_RUN) begin
        psc <= psc + 1'b1;
      end
    end
  end

  // Display scan runs in every state, independent of the counter control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      if (ref_cnt == RW'(REFRESH - 1)) begin
        ref_cnt <= '0;
        idx     <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an_q  <= ~(N_DIGITS'(1) << idx);
      seg_q <= seg_dec;
    end
  end

  assign cur_nib = 4'(cnt >> (4 * idx));

  seg7_decoder u_decoder (
    .nibble (cur_nib),
    .seg    (seg_dec)
  );

  assign {a, b, c, d, e, f, g} = seg_q;
  assign AN    = an_q;
  assign rdata = 32'(cnt);
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seg7_timer_param.sv
// Directed and randomized checks of the stopwatch counter, overflow and display scan.
module tb_seg7_timer_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_7seg;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic [7:0]  an_a;
  logic [1:0]  an_b, an_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_timer_param #(.N_DIGITS(8), .PRESCALE(1), .REFRESH(4)) dut_a (
    .clk(clk), .rst(rst), .we_7seg(we_7seg), .wdata(wdata), .rdata(rdata_a), .ovf(ovf_a),
    .a(seg_a[6]), .b(seg_a[5]), .c(seg_a[4]), .d(seg_a[3]), .e(seg_a[2]), .f(seg_a[1]),
    .g(seg_a[0]), .AN(an_a));

  seg7_timer_param #(.N_DIGITS(2), .PRESCALE(1), .REFRESH(4)) dut_b (
    .clk(clk), .rst(rst), .we_7seg(we_7seg), .wdata(wdata), .rdata(rdata_b), .ovf(ovf_b),
    .a(seg_b[6]), .b(seg_b[5]), .c(seg_b[4]), .d(seg_b[3]), .e(seg_b[2]), .f(seg_b[1]),
    .g(seg_b[0]), .AN(an_b));

  seg7_timer_param #(.N_DIGITS(2), .PRESCALE(3), .REFRESH(3)) dut_c (
    .clk(clk), .rst(rst), .we_7seg(we_7seg), .wdata(wdata), .rdata(rdata_c), .ovf(ovf_c),
    .a(seg_c[6]), .b(seg_c[5]), .c(seg_c[4]), .d(seg_c[3]), .e(seg_c[2]), .f(seg_c[1]),
    .g(seg_c[0]), .AN(an_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; the write is sampled on the following posedge
  task automatic cmd(input logic [1:0] c, input logic h);
    we_7seg = 1'b1;
    wdata   = {29'b0, h, c};
    @(negedge clk);
    we_7seg = 1'b0;
    wdata   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] bcd_of(input int v, input int nd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r = r | (32'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  initial begin
    logic [7:0] prev_an;
    logic [7:0] exp_an;
    int         k;
    int         ei;
    int         rc;
    int         t;
    int         lim;
    logic       running;
    logic       hx;
    logic [1:0] rcmd;
    logic       rh;

    rst     = 1'b1;
    we_7seg = 1'b0;
    wdata   = '0;
    idle(2);
    chk("reset_rdata", rdata_a, 32'h0);
    chk("reset_ovf", {31'b0, ovf_a}, 32'h0);
    chk("reset_an", {24'b0, an_a}, 32'hFF);
    chk("reset_seg", {25'b0, seg_a}, 32'h7F);
    rst = 1'b0;
    idle(1);

    // BCD count to 100 then hold
    cmd(2'b01, 1'b0);
    idle(100);
    chk("bcd100_run", rdata_a, 32'h100);
    cmd(2'b10, 1'b0);
    chk("bcd100_stop", rdata_a, 32'h100);
    idle(30);
    chk("bcd100_hold30", rdata_a, 32'h100);
    chk("bcd100_ovf", {31'b0, ovf_a}, 32'h0);

    // display scan while holding 0x100
    prev_an = an_a;
    k = 0;
    while (an_a === prev_an && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("scan_step_seen", {31'b0, (an_a !== prev_an)}, 32'h1);
    k = -1;
    for (int j = 0; j < 8; j++) begin
      exp_an = ~(8'b1 << j);
      if (an_a === exp_an) k = j;
    end
    chk("scan_onehot", {31'b0, (k >= 0)}, 32'h1);
    if (k < 0) k = 0;
    for (int j = 0; j < 32; j++) begin
      ei     = (k + j / 4) % 8;
      exp_an = ~(8'b1 << ei);
      chk("scan_an", {24'b0, an_a}, {24'b0, exp_an});
      chk("scan_seg", {25'b0, seg_a}, (ei == 2) ? 32'h4F : 32'h01);
      @(negedge clk);
    end

    // hex count
    cmd(2'b01, 1'b1);
    idle(75);
    cmd(2'b10, 1'b1);
    chk("hex75", rdata_a, 32'h4B);

    // stop / resume keeps the count
    cmd(2'b01, 1'b0);
    idle(40);
    cmd(2'b10, 1'b0);
    chk("resume_stop40", rdata_a, 32'h40);
    cmd(2'b11, 1'b0);
    idle(20);
    cmd(2'b10, 1'b0);
    chk("resume_total", rdata_a, 32'h60);
    chk("resume_ovf", {31'b0, ovf_a}, 32'h0);

    // two-digit overflow boundaries
    cmd(2'b01, 1'b0);
    idle(99);
    chk("b_bcd99", rdata_b, 32'h99);
    chk("b_bcd99_ovf", {31'b0, ovf_b}, 32'h0);
    idle(1);
    chk("b_bcd_wrap", rdata_b, 32'h00);
    chk("b_bcd_wrap_ovf", {31'b0, ovf_b}, 32'h1);
    idle(5);
    chk("b_ovf_sticky", {31'b0, ovf_b}, 32'h1);
    cmd(2'b01, 1'b1);
    chk("b_start_clr_ovf", {31'b0, ovf_b}, 32'h0);
    chk("b_start_clr_cnt", rdata_b, 32'h0);
    idle(255);
    chk("b_hexff", rdata_b, 32'hFF);
    chk("b_hexff_ovf", {31'b0, ovf_b}, 32'h0);
    idle(1);
    chk("b_hex_wrap", rdata_b, 32'h00);
    chk("b_hex_wrap_ovf", {31'b0, ovf_b}, 32'h1);

    // asynchronous reset mid-run
    cmd(2'b01, 1'b0);
    idle(37);
    chk("pre_rst37", rdata_a, 32'h37);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rdata", rdata_a, 32'h0);
    chk("async_rst_an", {24'b0, an_a}, 32'hFF);
    chk("async_rst_seg", {25'b0, seg_a}, 32'h7F);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    cmd(2'b10, 1'b0);
    idle(10);
    chk("idle_stop_frozen", rdata_a, 32'h0);

    // randomized commands against a cycle-count model on the prescaled instance
    running = 1'b0;
    rc      = 0;
    hx      = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      t   = rc / 3;
      lim = hx ? 256 : 100;
      chk("rand_cnt", rdata_c, hx ? 32'(t % lim) : bcd_of(t % lim, 2));
      chk("rand_ovf", {31'b0, ovf_c}, {31'b0, (t >= lim)});
      if ($urandom_range(0, 29) == 0) begin
        rcmd = 2'($urandom_range(0, 3));
        rh   = (rcmd == 2'b01) ? 1'($urandom_range(0, 1)) : hx;
        we_7seg = 1'b1;
        wdata   = {29'b0, rh, rcmd};
        case (rcmd)
          2'b01: begin rc = 0; running = 1'b1; hx = rh; end
          2'b10: running = 1'b0;
          2'b11: running = 1'b1;
          default: if (running) rc++;
        endcase
      end else begin
        we_7seg = 1'b0;
        wdata   = '0;
        if (running) rc++;
      end
      @(negedge clk);
    end
    we_7seg = 1'b0;
    wdata   = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_timer_param.md
SEG7_TIMER_PARAM -- requirements
Module: seg7_timer_param

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of displayed digits (legal 1..8).
REQ-002 SHALL have parameter PRESCALE, default 1, clock cycles per count tick (legal >=1).
REQ-003 SHALL have parameter REFRESH, default 4, clock cycles each digit stays selected (legal >=1).
REQ-004 SHALL have one clock and an asynchronous active-high reset, ports: clk  in  1  system clock; rst  in  1  reset.
REQ-005 SHALL have port we_7seg  in  1  control-register write strobe, sampled on rising clk.
REQ-006 SHALL have port wdata  in  32  write data; [1:0] command, [2] hex mode.
REQ-007 SHALL have port rdata  out  32  current count, zero-extended from 4*N_DIGITS bits.
REQ-008 SHALL have port ovf  out  1  sticky overflow flag.
REQ-009 SHALL have ports a,b,c,d,e,f,g  out  1 each  active-low segment drives.
REQ-010 SHALL have port AN  out  N_DIGITS  active-low one-hot digit enables.

Function
REQ-011 SHALL implement states IDLE, RUN, HOLD.
REQ-012 SHALL decode commands on we_7seg=1: 00 NOP; 01 START (count<=0, ovf<=0, prescaler<=0, ->RUN); 10 STOP (->HOLD, freeze count); 11 RESUME (->RUN, no clear).
REQ-013 SHALL ignore STOP when in IDLE; START in RUN or HOLD SHALL restart from zero.
REQ-014 SHALL latch wdata[2] into hex-mode register on every write (1=hex, 0=BCD), regardless of command.
REQ-015 SHALL increment count once per prescale tick, a tick occurring when the prescaler reaches PRESCALE-1 while in RUN; prescaler SHALL hold in IDLE/HOLD.
REQ-016 SHALL give commands priority over a coincident tick: no increment on the edge a command is sampled.
REQ-017 SHALL, in BCD mode, increment digits 0-9 with decimal carry; at all-nines SHALL wrap to zero and set ovf.
REQ-018 SHALL, in hex mode, increment as a 4*N_DIGITS-bit binary counter; at all-F SHALL wrap to zero and set ovf.
REQ-019 SHALL keep ovf set until START or reset.
REQ-020 SHALL scan digits continuously in every state: digit index advances 0..N_DIGITS-1 and wraps every REFRESH cycles.
REQ-021 SHALL display the live count in RUN and the frozen count in HOLD and IDLE; digit i shows count nibble i.
REQ-022 SHALL decode nibbles 0-F to standard hex glyphs; in BCD mode nibbles are always 0-9.
REQ-023 SHALL register a-g and AN (one cycle latency from index/count to pins).

Reset
REQ-024 SHALL on rst: state IDLE, count 0, ovf 0, hex-mode 0, prescaler 0, scan index 0, refresh counter 0.
REQ-025 SHALL drive AN all ones and a-g all ones while rst is high; reset mid-RUN SHALL discard the count.

Structure
REQ-026 SHALL place state enum, command encodings and segment glyph constants in package seg7_pkg.
REQ-027 SHALL instantiate one combinational sub-module seg7_decoder (nibble in, 7 active-low segments out).

Verification
REQ-028 SHALL verify: reset, START, 100 cycles we_7seg=0, STOP -> rdata=0x00000100 (BCD), state HOLD, unchanged 30 cycles later.
REQ-029 SHALL verify: START with wdata[2]=1, 75 cycles, STOP -> rdata=0x0000004B.
REQ-030 SHALL verify: STOP at 40, RESUME, 20 cycles, STOP -> rdata=0x00000060 (BCD), ovf=0.
REQ-031 SHALL verify: N_DIGITS=2, BCD, START, 100 cycles -> rdata=0x00, ovf=1; next START clears ovf.
REQ-032 SHALL verify: HOLD with count 0x00000100, REFRESH=4 -> AN steps FE,FD,FB..7F each 4 cycles; digit 2 shows "1" (a-g=1001111), others "0" (0000001).
REQ-033 SHALL verify: rst asserted mid-RUN at count 37 -> rdata=0, AN=FF, a-g all 1 same cycle (asynchronous); STOP in IDLE leaves state IDLE.
